// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, field offsets and
// guard/round/sticky helpers used by the adder and multiplier pipelines.
package fpu_pkg;

   localparam int FP_MENT_WIDTH = 23;
   localparam int FP_EXPO_WIDTH = 8;

   localparam logic [FP_EXPO_WIDTH-1:0] EXP_ALL_ONES = '1;

   localparam int GRS_GUARD  = 2;
   localparam int GRS_ROUND  = 1;
   localparam int GRS_STICKY = 0;

   // Packed float layout {sign, exponent, fraction}
   localparam int FRAC_LSB = 0;
   localparam int EXP_LSB  = FP_MENT_WIDTH;
   localparam int SIGN_BIT = FP_MENT_WIDTH + FP_EXPO_WIDTH;

   typedef struct packed {
      logic                     sign;
      logic [FP_EXPO_WIDTH-1:0] expo;
      logic [FP_MENT_WIDTH-1:0] frac;
   } fp32_t;

   // Round-to-nearest-even increment decision.
   function automatic logic rne_inc(input logic [2:0] grs, input logic lsb);
      return grs[GRS_GUARD] & (grs[GRS_ROUND] | grs[GRS_STICKY] | lsb);
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a fraction plus GRS bits.
// Specials (Inf/NaN) are never incremented so their payload passes through.
module fp_round_rne
   import fpu_pkg::*;
#(
   parameter int MENT_WIDTH = FP_MENT_WIDTH
) (
   input  logic [MENT_WIDTH-1:0] mant,
   input  logic [2:0]            grs,
   input  logic                  special,
   output logic [MENT_WIDTH:0]   mant_r,
   output logic                  inexact
);

   logic inc;

   always_comb begin
      inc     = !special && rne_inc(grs, mant[0]);
      mant_r  = {1'b0, mant} + {{MENT_WIDTH{1'b0}}, inc};
      inexact = |grs;
   end

endmodule

// File: rtl/addition_stage5.sv
// Adder stage 5: RNE rounding (slice A) then renormalize/pack (slice B),
// as a 2-deep elastic pipeline with valid/ready on both sides.
module addition_stage5
   import fpu_pkg::*;
#(
   parameter int MENT_WIDTH = FP_MENT_WIDTH,
   parameter int EXPO_WIDTH = FP_EXPO_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             valid_in,
   output logic                             ready_in,
   input  logic                             sign_in,
   input  logic [EXPO_WIDTH-1:0]            normalized_exponent_in,
   input  logic [MENT_WIDTH-1:0]            normalized_mentissa_in,
   input  logic [2:0]                       grs_in,
   output logic                             valid_out,
   input  logic                             ready_out,
   output logic [EXPO_WIDTH+MENT_WIDTH:0]   result_out,
   output logic                             overflow_out,
   output logic                             inexact_out
);

   localparam logic [EXPO_WIDTH-1:0] EXP_MAX = {EXPO_WIDTH{1'b1}};

   // Slice A state
   logic                  a_valid_q,   a_valid_d;
   logic                  a_sign_q,    a_sign_d;
   logic [EXPO_WIDTH-1:0] a_exp_q,     a_exp_d;
   logic [MENT_WIDTH:0]   a_mant_r_q,  a_mant_r_d;
   logic                  a_special_q, a_special_d;
   logic                  a_inexact_q, a_inexact_d;

   // Slice B state drives the outputs directly
   logic                            b_valid_q,   b_valid_d;
   logic [EXPO_WIDTH+MENT_WIDTH:0]  b_result_q,  b_result_d;
   logic                            b_overflow_q, b_overflow_d;
   logic                            b_inexact_q, b_inexact_d;

   logic                  in_special;
   logic [MENT_WIDTH:0]   rnd_mant_r;
   logic                  rnd_inexact;

   logic                  a_load, a_adv, b_drain;
   logic                  carry;
   logic [EXPO_WIDTH-1:0] exp_inc;
   logic [EXPO_WIDTH-1:0] pk_exp;
   logic [MENT_WIDTH-1:0] pk_frac;
   logic                  pk_ovf;

   assign in_special = (normalized_exponent_in == EXP_MAX);

   fp_round_rne #(
      .MENT_WIDTH (MENT_WIDTH)
   ) u_round (
      .mant    (normalized_mentissa_in),
      .grs     (grs_in),
      .special (in_special),
      .mant_r  (rnd_mant_r),
      .inexact (rnd_inexact)
   );

   // A may advance when B is empty or B empties this same edge.
   assign a_adv    = a_valid_q && (!b_valid_q || ready_out);
   assign b_drain  = b_valid_q && ready_out;
   assign ready_in = !a_valid_q || !b_valid_q || ready_out;
   assign a_load   = valid_in && ready_in;

   always_comb begin
      carry   = a_mant_r_q[MENT_WIDTH];
      exp_inc = a_exp_q + 1'b1;
      pk_exp  = a_exp_q;
      pk_frac = a_mant_r_q[MENT_WIDTH-1:0];
      pk_ovf  = 1'b0;
      // Carry-out means the fraction wrapped to zero; bump the exponent.
      if (carry) begin
         pk_exp  = exp_inc;
         pk_frac = '0;
         pk_ovf  = (exp_inc == EXP_MAX);
      end
   end

   always_comb begin
      a_valid_d   = a_valid_q;
      a_sign_d    = a_sign_q;
      a_exp_d     = a_exp_q;
      a_mant_r_d  = a_mant_r_q;
      a_special_d = a_special_q;
      a_inexact_d = a_inexact_q;
      if (a_adv)
         a_valid_d = 1'b0;
      if (a_load) begin
         a_valid_d   = 1'b1;
         a_sign_d    = sign_in;
         a_exp_d     = normalized_exponent_in;
         a_mant_r_d  = rnd_mant_r;
         a_special_d = in_special;
         a_inexact_d = rnd_inexact;
      end
   end

   always_comb begin
      b_valid_d    = b_valid_q;
      b_result_d   = b_result_q;
      b_overflow_d = b_overflow_q;
      b_inexact_d  = b_inexact_q;
      if (b_drain)
         b_valid_d = 1'b0;
      if (a_adv) begin
         b_valid_d    = 1'b1;
         b_result_d   = {a_sign_q, pk_exp, pk_frac};
         b_overflow_d = pk_ovf && !a_special_q;
         b_inexact_d  = a_inexact_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid_q    <= 1'b0;
         a_sign_q     <= 1'b0;
         a_exp_q      <= '0;
         a_mant_r_q   <= '0;
         a_special_q  <= 1'b0;
         a_inexact_q  <= 1'b0;
         b_valid_q    <= 1'b0;
         b_result_q   <= '0;
         b_overflow_q <= 1'b0;
         b_inexact_q  <= 1'b0;
      end else begin
         a_valid_q    <= a_valid_d;
         a_sign_q     <= a_sign_d;
         a_exp_q      <= a_exp_d;
         a_mant_r_q   <= a_mant_r_d;
         a_special_q  <= a_special_d;
         a_inexact_q  <= a_inexact_d;
         b_valid_q    <= b_valid_d;
         b_result_q   <= b_result_d;
         b_overflow_q <= b_overflow_d;
         b_inexact_q  <= b_inexact_d;
      end
   end

   assign valid_out    = b_valid_q;
   assign result_out   = b_result_q;
   assign overflow_out = b_overflow_q;
   assign inexact_out  = b_inexact_q;

endmodule
